mul_div_unit: RTL

- Multi-cycle multiply/divide unit in the EX stage; sink for the EX controller's start, mul_divop, hilowrite and hilo outputs.
- Owns the HI/LO registers and provides busy so hazard logic can stall dependent instructions (mfhi/mflo/mthi/mtlo/muldiv) while an operation is in flight.
- Models fixed mult/div latency with a down-counter; results commit to HI/LO only at completion.

---
 rtl/mul_div_unit_if.sv | 24 ++
 rtl/mul_div_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: EX-stage controller <-> multiply/divide unit bundle.
// The controller side (master) issues operations and HI/LO writes; the
// unit side (slave) returns busy and the architectural HI/LO registers.
interface mul_div_unit_if;
    logic        start;
    logic [2:0]  mul_divop;
    logic [31:0] D1;
    logic [31:0] D2;
    logic        hilowrite;
    logic        hilo;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, mul_divop, D1, D2, hilowrite, hilo,
        input  busy, HI, LO
    );

    modport slave (
        input  start, mul_divop, D1, D2, hilowrite, hilo,
        output busy, HI, LO
    );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle multiply/divide unit owning HI/LO.
// The result is computed on the accepting edge into pending registers and
// committed to HI/LO only when the latency down-counter expires, so busy
// models the fixed pipeline latency seen by hazard logic.
// Optional feature macro: MDU_MADD_EN (mul_divop 100 = maddu, 101 = madd).
module mul_div_unit #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic          clk,
    input  logic          reset,
    mul_div_unit_if.slave mdu
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

    // Signedness comes from op bit 0 for every arithmetic op
    // (multu/mult, divu/div, maddu/madd), so one multiplier and one
    // divider serve both flavours.
    logic        is_signed;
    logic [63:0] ext_a, ext_b, product;
    logic        neg_a, neg_b, div_by_zero;
    logic [31:0] mag_a, mag_b, mag_b_safe;
    logic [31:0] quot_mag, rem_mag, quotient, remainder;

    assign is_signed = mdu.mul_divop[0];

    // Low 64 bits of the product of sign/zero-extended operands are the
    // exact signed/unsigned 64-bit product.
    assign ext_a   = {{32{is_signed & mdu.D1[31]}}, mdu.D1};
    assign ext_b   = {{32{is_signed & mdu.D2[31]}}, mdu.D2};
    assign product = ext_a * ext_b;

    // Signed division via magnitudes: quotient truncates toward zero and
    // the remainder follows the dividend's sign. 0x80000000 / -1 falls out
    // naturally as 0x80000000 remainder 0 in 32-bit wrap arithmetic.
    assign neg_a       = is_signed & mdu.D1[31];
    assign neg_b       = is_signed & mdu.D2[31];
    assign mag_a       = neg_a ? (32'd0 - mdu.D1) : mdu.D1;
    assign mag_b       = neg_b ? (32'd0 - mdu.D2) : mdu.D2;
    assign div_by_zero = (mdu.D2 == 32'd0);
    // Divisor forced non-zero so the divider never sees 0; the result is
    // discarded in that case anyway.
    assign mag_b_safe  = div_by_zero ? 32'd1 : mag_b;
    assign quot_mag    = mag_a / mag_b_safe;
    assign rem_mag     = mag_a % mag_b_safe;
    assign quotient    = (neg_a ^ neg_b) ? (32'd0 - quot_mag) : quot_mag;
    assign remainder   = neg_a ? (32'd0 - rem_mag) : rem_mag;

`ifdef MDU_MADD_EN
    // Accumulate against HI/LO as they stand when the op is accepted.
    logic [63:0] acc_sum;
    assign acc_sum = {hi_q, lo_q} + product;
`endif

    // State, counter, HI/LO and pending registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            // NOTE: pending registers are reset too, so an aborted op can
            // never leak a stale result into HI/LO later.
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating
            // from the same pre-edge values regardless of statement order.
            state_q   <= state_d;
            count_q   <= count_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    // Next-state: accept ops or HI/LO writes in IDLE, count down and commit in RUN.
    always_comb begin
        // NOTE: every output gets a hold-value default first so no path
        // through the case statements can infer a latch.
        state_d   = state_q;
        count_d   = count_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;

        unique case (state_q)
            IDLE: begin
                if (mdu.start) begin
                    // start takes priority; a coincident hilowrite is dropped.
                    case (mdu.mul_divop)
                        3'b000, 3'b001: begin
                            {pend_hi_d, pend_lo_d} = product;
                            count_d                = CW'(MUL_CYCLES);
                            state_d                = RUN;
                        end
                        3'b010, 3'b011: begin
                            if (div_by_zero) begin
                                pend_hi_d = hi_q;
                                pend_lo_d = lo_q;
                            end else begin
                                pend_hi_d = remainder;
                                pend_lo_d = quotient;
                            end
                            count_d = CW'(DIV_CYCLES);
                            state_d = RUN;
                        end
`ifdef MDU_MADD_EN
                        3'b100, 3'b101: begin
                            {pend_hi_d, pend_lo_d} = acc_sum;
                            count_d                = CW'(MUL_CYCLES);
                            state_d                = RUN;
                        end
`endif
                        default: ;  // reserved op: no-op
                    endcase
                end else if (mdu.hilowrite) begin
                    if (mdu.hilo) hi_d = mdu.D1;
                    else          lo_d = mdu.D1;
                end
            end
            RUN: begin
                // start and hilowrite are ignored while an op is in flight.
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mdu.busy = (state_q == RUN);
    assign mdu.HI   = hi_q;
    assign mdu.LO   = lo_q;

endmodule
